icache: RTL and testbench

Direct-mapped, read-only instruction cache between the pipelined datapath's instruction fetch port and the memory controller's instruction port. Hits return in the same cycle the request is presented. Misses run a fetch FSM that holds the datapath stalled, via `ihit` low, until memory returns the word and the frame is filled. Also provides a whole-cache flush and a saturating miss counter for performance runs.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/icache.sv | 102 ++++++++++
 tb/tb_icache.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the instruction cache
package cpu_types_pkg;

  // Index width of the default 16-frame instruction cache.
  localparam int ICACHE_IDXW = 4;
  localparam int ICACHE_TAGW = 32 - ICACHE_IDXW - 2;

  // Fetch address split: tag, frame index, byte offset.
  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDXW-1:0] idx;
    logic [1:0]             bytoff;
  } icachef_t;

  // Miss-handling FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with miss counter
module icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int IDXW  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [15:0] miss_count
);

  localparam int TAGW = 30 - IDXW;

  icache_state_t state, next_state;
  logic [31:0]      fetch_addr;
  logic [NSETS-1:0] valid;
  logic [TAGW-1:0]  tags [NSETS];
  logic [31:0]      data [NSETS];
  logic [15:0]      miss_cnt;

  logic [IDXW-1:0]  req_idx, fill_idx;
  logic [TAGW-1:0]  req_tag, fill_tag;
  logic             hit, miss_start, fill;

  assign req_tag    = imemaddr[31:IDXW+2];
  assign req_idx    = imemaddr[IDXW+1:2];
  assign fill_tag   = fetch_addr[31:IDXW+2];
  assign fill_idx   = fetch_addr[IDXW+1:2];
  assign miss_count = miss_cnt;

  // Lookup, next-state and outputs; FETCH outputs depend only on state and fetch_addr.
  always_comb begin
    next_state = state;
    hit        = 1'b0;
    miss_start = 1'b0;
    fill       = 1'b0;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    case (state)
      IDLE: begin
        hit      = imemREN & valid[req_idx] & (tags[req_idx] == req_tag);
        ihit     = hit & ~flush;
        imemload = hit ? data[req_idx] : 32'h0;
        if (imemREN & ~hit & ~flush) begin
          miss_start = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = fetch_addr;
        fill  = ~iwait & ~flush;
        if (~iwait) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // Flush wins over any pending transition; an in-flight fill is simply dropped.
    if (flush) begin
      next_state = IDLE;
    end
  end

  // State, miss address, frame arrays and saturating miss counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      valid      <= '0;
      fetch_addr <= 32'h0;
      miss_cnt   <= 16'h0;
    end else begin
      state <= next_state;
      if (flush) begin
        valid <= '0;
      end else if (fill) begin
        valid[fill_idx] <= 1'b1;
        tags[fill_idx]  <= fill_tag;
        data[fill_idx]  <= iload;
      end
      if (miss_start) begin
        fetch_addr <= imemaddr;
        if (miss_cnt != 16'hFFFF) begin
          miss_cnt <= miss_cnt + 16'h1;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which full address each of the 16 frames currently holds.
  logic        m_valid [16];
  logic [31:0] m_addr  [16];
  logic [15:0] m_cnt;

  icache #(.NSETS(16), .IDXW(4)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h40) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    int i;
    i = int'(a[5:2]);
    return m_valid[i] && (m_addr[i][31:6] == a[31:6]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One fetch of address a; on a miss the memory answers after w busy cycles.
  task automatic access(input logic [31:0] a, input int w, input logic exp_hit);
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1; flush = 1'b0;
    #1;
    chk("ihit_lookup", {31'h0, ihit}, {31'h0, exp_hit});
    chk("iREN_idle", {31'h0, iREN}, 32'h0);
    if (exp_hit) begin
      chk("imemload_hit", imemload, memword(a));
    end else begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      @(posedge CLK);
      for (int k = 0; k <= w; k++) begin
        @(negedge CLK);
        iwait    = (k < w);
        iload    = (k < w) ? $urandom : memword(a);
        imemaddr = $urandom;
        imemREN  = 1'($urandom_range(0, 1));
        #1;
        chk("iREN_fetch", {31'h0, iREN}, 32'h1);
        chk("iaddr_fetch", iaddr, a);
        chk("ihit_fetch", {31'h0, ihit}, 32'h0);
        @(posedge CLK);
      end
      m_valid[a[5:2]] = 1'b1;
      m_addr[a[5:2]]  = a;
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = $urandom;
      #1;
      chk("ihit_after_fill", {31'h0, ihit}, 32'h1);
      chk("imemload_after_fill", imemload, memword(a));
      chk("iREN_after_fill", {31'h0, iREN}, 32'h0);
    end
    chk("miss_count", {16'h0, miss_count}, {16'h0, m_cnt});
  endtask

  typedef struct {
    logic [31:0] addr;
    int          w;
    logic        exp_hit;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] a;

    vecs[0]  = '{32'h0000_0040, 0, 1'b0, 16'd1};
    vecs[1]  = '{32'h0000_0040, 0, 1'b1, 16'd1};
    vecs[2]  = '{32'h0000_0080, 3, 1'b0, 16'd2};
    vecs[3]  = '{32'h0000_0080, 0, 1'b1, 16'd2};
    vecs[4]  = '{32'h0000_0040, 0, 1'b0, 16'd3};
    vecs[5]  = '{32'h0000_0044, 2, 1'b0, 16'd4};
    vecs[6]  = '{32'h0000_0044, 0, 1'b1, 16'd4};
    vecs[7]  = '{32'h0000_0080, 0, 1'b0, 16'd5};
    vecs[8]  = '{32'h0000_07FC, 1, 1'b0, 16'd6};
    vecs[9]  = '{32'h0000_003C, 0, 1'b0, 16'd7};
    vecs[10] = '{32'h0000_07FC, 0, 1'b0, 16'd8};

    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0;
    iwait = 1'b1; iload = 32'h0;
    model_clear();
    m_cnt = 16'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_ihit", {31'h0, ihit}, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iREN", {31'h0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_miss_count", {16'h0, miss_count}, 32'h0);

    // Directed table: cold miss, hit, conflicts on index 0 and 15.
    for (int i = 0; i < 11; i++) begin
      access(vecs[i].addr, vecs[i].w, vecs[i].exp_hit);
      chk("table_cnt", {16'h0, miss_count}, {16'h0, vecs[i].exp_cnt});
    end

    // Flush in the same cycle iwait falls: the fill must be dropped.
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h0000_0100; iwait = 1'b1;
    #1;
    chk("pre_flush_miss", {31'h0, ihit}, 32'h0);
    m_cnt = m_cnt + 16'h1;
    @(posedge CLK);
    @(negedge CLK);
    iwait = 1'b0; iload = memword(32'h100); flush = 1'b1;
    #1;
    chk("flush_fetch_iREN", {31'h0, iREN}, 32'h1);
    chk("flush_fetch_ihit", {31'h0, ihit}, 32'h0);
    @(posedge CLK);
    model_clear();
    access(32'h0000_0100, 0, 1'b0);
    access(32'h0000_0044, 0, 1'b0);

    // Reset in mid-FETCH clears everything.
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h0000_0200; iwait = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1; iwait = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0000_0100;
    #1;
    chk("midrst_iREN", {31'h0, iREN}, 32'h0);
    chk("midrst_ihit", {31'h0, ihit}, 32'h0);
    chk("midrst_cnt", {16'h0, miss_count}, 32'h0);
    imemREN = 1'b0;
    model_clear();
    m_cnt = 16'h0;
    access(32'h0000_0100, 0, 1'b0);
    access(32'h0000_0044, 1, 1'b0);

    // Randomised traffic with occasional idle flushes.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge CLK);
        flush = 1'b1; imemREN = 1'b1;
        imemaddr = m_addr[$urandom_range(0, 15)];
        #1;
        chk("flush_ihit", {31'h0, ihit}, 32'h0);
        @(posedge CLK);
        model_clear();
      end else begin
        a = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0,
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
        access(a, $urandom_range(0, 3), model_hit(a));
      end
    end

    // Saturation: preload the counter near its limit, then miss three times.
    @(negedge CLK);
    imemREN = 1'b0; flush = 1'b1;
    force dut.miss_cnt = 16'hFFFD;
    #1;
    release dut.miss_cnt;
    @(posedge CLK);
    model_clear();
    m_cnt = 16'hFFFD;
    access(32'h0000_0300, 0, 1'b0);
    chk("sat_fffe", {16'h0, miss_count}, 32'h0000_FFFE);
    access(32'h0000_0304, 0, 1'b0);
    chk("sat_ffff", {16'h0, miss_count}, 32'h0000_FFFF);
    access(32'h0000_0308, 0, 1'b0);
    chk("sat_hold", {16'h0, miss_count}, 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
